// File: rtl/dw_win_pkg.sv
// Shared constants, FSM state type and tap-offset helper for the 3x3 depthwise window generator.
package dw_win_pkg;

  localparam int unsigned KSIZE = 3;
  localparam int unsigned TAPS  = KSIZE * KSIZE;

  typedef enum logic [0:0] {ACCEPT, PAD} state_e;

  // Bit offset of tap k (row*3+col) of channel c in the packed window bus.
  function automatic int unsigned tap_lsb(input int unsigned c, input int unsigned k,
                                          input int unsigned act_w = 8);
    return (c * TAPS + k) * act_w;
  endfunction

endpackage

// File: rtl/dw_window_gen_if.sv
// Pixel-in / window-out handshake bundle for dw_window_gen.
interface dw_window_gen_if
  import dw_win_pkg::*;
#(
  parameter int unsigned CH    = 16,
  parameter int unsigned ACT_W = 8
);

  logic                        in_valid;
  logic                        in_ready;
  logic [CH*ACT_W-1:0]         in_pix;
  logic                        out_valid;
  logic                        out_ready;
  logic [TAPS*CH*ACT_W-1:0]    out_window;
  logic                        out_last;

  modport slave (
    input  in_valid, in_pix, out_ready,
    output in_ready, out_valid, out_window, out_last
  );

  modport master (
    output in_valid, in_pix, out_ready,
    input  in_ready, out_valid, out_window, out_last
  );

endinterface

// File: rtl/dw_line_buf.sv
// One image row of pixels; combinational read of the old entry, write of the new one on the clock.
module dw_line_buf #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 128,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic             we_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dw_window_gen.sv
// Streaming 3x3xCH sliding-window generator over a virtual raster of VW x VH positions.
// Define DW_WINDOW_SAME_PAD_EN for a one-pixel zero ring ("same" padding); default is "valid".
module dw_window_gen
  import dw_win_pkg::*;
#(
  parameter int unsigned CH    = 16,
  parameter int unsigned ACT_W = 8,
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8
) (
  input logic            clk,
  input logic            rst,
  dw_window_gen_if.slave bus_io
);

`ifdef DW_WINDOW_SAME_PAD_EN
  localparam int unsigned P = 1;
  localparam state_e StReset = PAD;
`else
  localparam int unsigned P = 0;
  localparam state_e StReset = ACCEPT;
`endif
  localparam int unsigned VW   = IMG_W + 2 * P;
  localparam int unsigned VH   = IMG_H + 2 * P;
  localparam int unsigned PixW = CH * ACT_W;
  localparam int unsigned WinW = TAPS * PixW;
  localparam int unsigned VcW  = $clog2(VW);
  localparam int unsigned VrW  = $clog2(VH);

  typedef logic [PixW-1:0] pix_t;

  logic [VcW-1:0] vc_q, vc_d;
  logic [VrW-1:0] vr_q, vr_d;
  state_e         state_q, state_d;
  logic           out_valid_q, out_last_q;
  logic [WinW-1:0] out_window_q, win_next;

  pix_t win_q   [KSIZE][KSIZE-1];
  pix_t tap_src [KSIZE][KSIZE];
  pix_t new_col [KSIZE];
  pix_t lb0_rd, lb1_rd, src_pix;
  logic is_real, out_free, step, emit, at_last;

  always_comb begin
    is_real  = (state_q == ACCEPT);
    out_free = !out_valid_q || bus_io.out_ready;
    step     = (is_real ? bus_io.in_valid : 1'b1) && out_free;
    src_pix  = is_real ? bus_io.in_pix : '0;
    new_col[0] = lb1_rd;
    new_col[1] = lb0_rd;
    new_col[2] = src_pix;
    emit    = step && (vr_q >= VrW'(2)) && (vc_q >= VcW'(2));
    at_last = (vr_q == VrW'(VH - 1)) && (vc_q == VcW'(VW - 1));

    vc_d = vc_q + 1'b1;
    vr_d = vr_q;
    if (vc_q == VcW'(VW - 1)) begin
      vc_d = '0;
      vr_d = (vr_q == VrW'(VH - 1)) ? '0 : vr_q + 1'b1;
    end

`ifdef DW_WINDOW_SAME_PAD_EN
    state_d = ((vr_d >= VrW'(1)) && (vr_d <= VrW'(VH - 2)) &&
               (vc_d >= VcW'(1)) && (vc_d <= VcW'(VW - 2))) ? ACCEPT : PAD;
`else
    state_d = ACCEPT;
`endif

    // Columns 0/1 come from the shift registers, column 2 is the column entering this step.
    for (int r = 0; r < KSIZE; r++) begin
      tap_src[r][0] = win_q[r][0];
      tap_src[r][1] = win_q[r][1];
      tap_src[r][2] = new_col[r];
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    for (genvar r = 0; r < KSIZE; r++) begin : g_row
      for (genvar k = 0; k < KSIZE; k++) begin : g_col
        assign win_next[tap_lsb(c, r * KSIZE + k, ACT_W) +: ACT_W] =
            tap_src[r][k][c*ACT_W +: ACT_W];
      end
    end
  end

  dw_line_buf #(
    .Depth (VW),
    .Width (PixW)
  ) u_lb0 (
    .clk_i   (clk),
    .addr_i  (vc_q),
    .we_i    (step),
    .wdata_i (src_pix),
    .rdata_o (lb0_rd)
  );

  dw_line_buf #(
    .Depth (VW),
    .Width (PixW)
  ) u_lb1 (
    .clk_i   (clk),
    .addr_i  (vc_q),
    .we_i    (step),
    .wdata_i (lb0_rd),
    .rdata_o (lb1_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vc_q         <= '0;
      vr_q         <= '0;
      state_q      <= StReset;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_window_q <= '0;
      for (int r = 0; r < KSIZE; r++) begin
        win_q[r][0] <= '0;
        win_q[r][1] <= '0;
      end
    end else begin
      if (step) begin
        vc_q    <= vc_d;
        vr_q    <= vr_d;
        state_q <= state_d;
        for (int r = 0; r < KSIZE; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= new_col[r];
        end
      end
      // A new window overrides a same-cycle drain, so out_valid stays high.
      if (emit) begin
        out_valid_q  <= 1'b1;
        out_last_q   <= at_last;
        out_window_q <= win_next;
      end else if (bus_io.out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign bus_io.in_ready   = is_real && out_free;
  assign bus_io.out_valid  = out_valid_q;
  assign bus_io.out_last   = out_last_q;
  assign bus_io.out_window = out_window_q;

endmodule
